conv1d_stream_p: RTL and testbench

Parametrised streaming 1-D convolution layer with P parallel saturating MAC lanes and a runtime-loadable filter. It accepts an LENX-sample input vector on a valid/ready slave port and computes LENY = LENX-LENF+1 outputs, P per group. It returns the outputs in order on a valid/ready master port. It is the general successor to the fixed-ROM, fixed-size layerN_* convolution layers and sits between adjacent layers in the network pipeline.

---
 rtl/conv1d_stream_p_pkg.sv | 37 +++
 rtl/conv1d_stream_p_if.sv | 24 ++
 rtl/conv1d_mac_lane.sv | 46 ++++
 rtl/conv1d_stream_p.sv | 197 +++++++++++++++++++
 tb/tb_conv1d_stream_p.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/conv1d_stream_p_pkg.sv
// conv1d_pkg: shared types and helpers for the conv1d_stream_p convolution layer.
// Holds the FSM state encoding, generic saturation and the LENY/G derivations.
package conv1d_pkg;

  typedef enum logic [1:0] {
    LOAD_F  = 2'd0,
    LOAD_X  = 2'd1,
    COMPUTE = 2'd2,
    OUT     = 2'd3
  } state_e;

  // Number of outputs of a valid (no padding) convolution.
  function automatic int leny(input int lenx, input int lenf);
    return lenx - lenf + 1;
  endfunction

  // Number of lane groups needed to cover all outputs.
  function automatic int groups(input int ly, input int p);
    return (ly + p - 1) / p;
  endfunction

  // Counter width able to hold 0..mx; never narrower than one bit.
  function automatic int cw(input int mx);
    return (mx < 1) ? 1 : $clog2(mx + 1);
  endfunction

  // Clamp a wide signed value into the w-bit signed range.
  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/conv1d_stream_p_if.sv
// conv1d_stream_p_if: coefficient, input-sample and output-sample streams.
// slave is the layer's view, master is the view of whoever drives the layer.
interface conv1d_stream_p_if #(parameter int WIDTH = 8);
  logic signed [WIDTH-1:0] s_data_f;
  logic                    s_valid_f;
  logic                    s_ready_f;
  logic                    f_reload;
  logic signed [WIDTH-1:0] s_data_in_x;
  logic                    s_valid_x;
  logic                    s_ready_x;
  logic signed [WIDTH-1:0] m_data_out_y;
  logic                    m_valid_y;
  logic                    m_ready_y;

  modport slave (
    input  s_data_f, s_valid_f, f_reload, s_data_in_x, s_valid_x, m_ready_y,
    output s_ready_f, s_ready_x, m_data_out_y, m_valid_y
  );

  modport master (
    output s_data_f, s_valid_f, f_reload, s_data_in_x, s_valid_x, m_ready_y,
    input  s_ready_f, s_ready_x, m_data_out_y, m_valid_y
  );
endinterface

// File: rtl/conv1d_mac_lane.sv
// conv1d_mac_lane: one saturating multiply-accumulate lane.
// Optional macro CONV1D_RELU_EN clamps negative results to zero on acc_o.
// acc_o is the post-update value so the last tap can be captured in the same cycle.
module conv1d_mac_lane
  import conv1d_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] x_i,
  input  logic signed [WIDTH-1:0] f_i,
  input  logic                    clr_i,
  input  logic                    en_i,
  output logic signed [WIDTH-1:0] acc_o
);

  logic signed [WIDTH-1:0]   acc_q, acc_d;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [63:0]        prod_sat, sum_w, sum_sat;

  // Saturate the product, then saturate the running sum; clr restarts from zero.
  always_comb begin
    prod     = x_i * f_i;
    prod_sat = sat(64'(prod), WIDTH);
    sum_w    = (clr_i ? 64'sd0 : 64'(acc_q)) + prod_sat;
    sum_sat  = sat(sum_w, WIDTH);
    acc_d    = en_i ? WIDTH'(sum_sat) : acc_q;
  end

  // Result stage: optional ReLU after saturation.
  always_comb begin
    acc_o = acc_d;
`ifdef CONV1D_RELU_EN
    if (acc_d[WIDTH-1]) acc_o = '0;
`else
`endif
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

endmodule

// File: rtl/conv1d_stream_p.sv
// conv1d_stream_p: streaming 1-D convolution with P parallel MAC lanes and a
// runtime-loadable filter. Loads LENF coefficients, then LENX samples, computes
// LENY outputs in ceil(LENY/P) groups of LENF cycles, then streams them out.
// Optional macro CONV1D_RELU_EN enables a ReLU on every output (in the lanes).
module conv1d_stream_p
  import conv1d_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LENX  = 5,
  parameter int LENF  = 3,
  parameter int P     = 1
) (
  input  logic              clk,
  input  logic              reset,
  conv1d_stream_p_if.slave  bus
);

  localparam int LENY = leny(LENX, LENF);
  localparam int G    = groups(LENY, P);
  localparam int KW   = cw(LENF);
  localparam int NW   = cw(LENX);
  localparam int GW   = cw(G);
  localparam int OW   = cw(LENY);

  state_e                        state_q, state_d;
  logic [KW-1:0]                 k_q, k_d;
  logic [NW-1:0]                 n_q, n_d;
  logic [GW-1:0]                 g_q, g_d;
  logic [OW-1:0]                 o_q, o_d;
  logic [LENF-1:0][WIDTH-1:0]    f_q, f_d;
  logic [LENX-1:0][WIDTH-1:0]    x_q, x_d;
  logic [LENY-1:0][WIDTH-1:0]    y_q, y_d;
  logic                          s_ready_f_q, s_ready_f_d;
  logic                          s_ready_x_q, s_ready_x_d;
  logic                          m_valid_q, m_valid_d;
  logic [WIDTH-1:0]              m_data_q, m_data_d;

  logic [WIDTH-1:0]              f_cur;
  logic [P-1:0][WIDTH-1:0]       lane_x;
  logic [P-1:0][WIDTH-1:0]       lane_y;
  logic                          lane_clr, lane_en;
  logic                          hs_f, hs_x, hs_y;

  assign hs_f = bus.s_valid_f & s_ready_f_q;
  assign hs_x = bus.s_valid_x & s_ready_x_q;
  assign hs_y = m_valid_q & bus.m_ready_y;

  // Operand fetch: tap k for all lanes; lane i of group g reads x[g*P+i+k].
  // Lanes past the end read zero; their results are dropped anyway.
  always_comb begin
    f_cur = '0;
    for (int j = 0; j < LENF; j++)
      if (k_q == KW'(j)) f_cur = f_q[j];
    for (int i = 0; i < P; i++) begin
      lane_x[i] = '0;
      for (int j = 0; j < LENX; j++)
        if (int'(g_q) * P + i + int'(k_q) == j) lane_x[i] = x_q[j];
    end
  end

  for (genvar i = 0; i < P; i++) begin : g_lane
    conv1d_mac_lane #(.WIDTH(WIDTH)) u_lane (
      .clk   (clk),
      .reset (reset),
      .x_i   (lane_x[i]),
      .f_i   (f_cur),
      .clr_i (lane_clr),
      .en_i  (lane_en),
      .acc_o (lane_y[i])
    );
  end

  // Next-state, counters, storage writes and lane control.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    n_d      = n_q;
    g_d      = g_q;
    o_d      = o_q;
    f_d      = f_q;
    x_d      = x_q;
    y_d      = y_q;
    lane_en  = 1'b0;
    lane_clr = 1'b0;
    case (state_q)
      LOAD_F: begin
        if (hs_f) begin
          for (int j = 0; j < LENF; j++)
            if (k_q == KW'(j)) f_d[j] = bus.s_data_f;
          if (k_q == KW'(LENF - 1)) begin
            k_d     = '0;
            state_d = LOAD_X;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end
      LOAD_X: begin
        if (hs_x) begin
          for (int j = 0; j < LENX; j++)
            if (n_q == NW'(j)) x_d[j] = bus.s_data_in_x;
          if (n_q == NW'(LENX - 1)) begin
            n_d     = '0;
            k_d     = '0;
            g_d     = '0;
            state_d = COMPUTE;
          end else begin
            n_d = n_q + NW'(1);
          end
        end else if (bus.f_reload && n_q == '0) begin
          // Reload only between vectors so a half-loaded x is never orphaned.
          k_d     = '0;
          state_d = LOAD_F;
        end
      end
      COMPUTE: begin
        lane_en  = 1'b1;
        lane_clr = (k_q == '0);
        if (k_q == KW'(LENF - 1)) begin
          for (int i = 0; i < P; i++)
            for (int j = 0; j < LENY; j++)
              if (int'(g_q) * P + i == j) y_d[j] = lane_y[i];
          k_d = '0;
          if (g_q == GW'(G - 1)) begin
            g_d     = '0;
            o_d     = '0;
            state_d = OUT;
          end else begin
            g_d = g_q + GW'(1);
          end
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      OUT: begin
        if (hs_y) begin
          if (o_q == OW'(LENY - 1)) begin
            o_d     = '0;
            state_d = LOAD_X;
          end else begin
            o_d = o_q + OW'(1);
          end
        end
      end
      default: state_d = LOAD_F;
    endcase
  end

  // Registered port outputs derived from the next state; data reads the
  // next buffer contents so y[0] is ready even when it is written on the last edge.
  always_comb begin
    s_ready_f_d = (state_d == LOAD_F);
    s_ready_x_d = (state_d == LOAD_X);
    m_valid_d   = (state_d == OUT);
    m_data_d    = '0;
    if (state_d == OUT)
      for (int j = 0; j < LENY; j++)
        if (o_d == OW'(j)) m_data_d = y_d[j];
  end

  // State, counters, storage and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= LOAD_F;
      k_q         <= '0;
      n_q         <= '0;
      g_q         <= '0;
      o_q         <= '0;
      f_q         <= '0;
      x_q         <= '0;
      y_q         <= '0;
      s_ready_f_q <= 1'b1;
      s_ready_x_q <= 1'b0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      n_q         <= n_d;
      g_q         <= g_d;
      o_q         <= o_d;
      f_q         <= f_d;
      x_q         <= x_d;
      y_q         <= y_d;
      s_ready_f_q <= s_ready_f_d;
      s_ready_x_q <= s_ready_x_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
    end
  end

  assign bus.s_ready_f    = s_ready_f_q;
  assign bus.s_ready_x    = s_ready_x_q;
  assign bus.m_valid_y    = m_valid_q;
  assign bus.m_data_out_y = m_data_q;

endmodule

// File: tb/tb_conv1d_stream_p.sv
// tb_conv1d_stream_p: directed bench driving a P=1 and a P=2 instance in lockstep
// with identical stimulus; expected outputs are hand-computed constants.
module tb_conv1d_stream_p;

  localparam int W = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic signed [W-1:0] f_data, x_data;
  logic                f_valid, x_valid, reload, y_ready;

  conv1d_stream_p_if #(.WIDTH(W)) ifa ();
  conv1d_stream_p_if #(.WIDTH(W)) ifb ();

  assign ifa.s_data_f    = f_data;
  assign ifa.s_valid_f   = f_valid;
  assign ifa.f_reload    = reload;
  assign ifa.s_data_in_x = x_data;
  assign ifa.s_valid_x   = x_valid;
  assign ifa.m_ready_y   = y_ready;
  assign ifb.s_data_f    = f_data;
  assign ifb.s_valid_f   = f_valid;
  assign ifb.f_reload    = reload;
  assign ifb.s_data_in_x = x_data;
  assign ifb.s_valid_x   = x_valid;
  assign ifb.m_ready_y   = y_ready;

  conv1d_stream_p #(.WIDTH(W), .LENX(5), .LENF(3), .P(1)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa));
  conv1d_stream_p #(.WIDTH(W), .LENX(5), .LENF(3), .P(2)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb));

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int hs_cyc = 0;

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int r(input int v);
`ifdef CONV1D_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  task automatic tick;
    @(negedge clk);
    cyc++;
  endtask

  task automatic load_f(input int c0, input int c1, input int c2);
    int c[3];
    c = '{c0, c1, c2};
    for (int i = 0; i < 3; i++) begin
      int t;
      t = 0;
      f_data = W'(c[i]);
      while (!(ifa.s_ready_f && ifb.s_ready_f) && t < 50) begin tick; t++; end
      chk("f_ready_wait", t < 50, 1);
      f_valid = 1'b1;
      tick;
      f_valid = 1'b0;
    end
  endtask

  task automatic send_x(input int a0, input int a1, input int a2, input int a3, input int a4);
    int v[5];
    v = '{a0, a1, a2, a3, a4};
    for (int i = 0; i < 5; i++) begin
      int t;
      t = 0;
      x_data = W'(v[i]);
      while (!(ifa.s_ready_x && ifb.s_ready_x) && t < 50) begin tick; t++; end
      chk("x_ready_wait", t < 50, 1);
      x_valid = 1'b1;
      if (i == 4) hs_cyc = cyc;
      tick;
      x_valid = 1'b0;
    end
  endtask

  // Drains both instances, checking hold-during-stall, busy readiness and latency.
  task automatic collect(input int e0, input int e1, input int e2, input bit rnd);
    logic signed [W-1:0] qa[$];
    logic signed [W-1:0] qb[$];
    logic signed [W-1:0] pd;
    int e[3];
    int fa, fb, t;
    bit stall;
    e = '{e0, e1, e2};
    fa = -1; fb = -1; t = 0; stall = 1'b0; pd = '0;
    while ((qa.size() < 3 || qb.size() < 3) && t < 300) begin
      y_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stall) begin
        chk("hold_valid", ifa.m_valid_y, 1);
        chk("hold_data", ifa.m_data_out_y, pd);
      end
      if (ifa.m_valid_y && fa < 0) fa = cyc - hs_cyc;
      if (ifb.m_valid_y && fb < 0) fb = cyc - hs_cyc;
      if (qa.size() < 3) chk("ready_x_busy", ifa.s_ready_x, 0);
      stall = ifa.m_valid_y && !y_ready;
      pd    = ifa.m_data_out_y;
      if (ifa.m_valid_y && y_ready) qa.push_back(ifa.m_data_out_y);
      if (ifb.m_valid_y && y_ready) qb.push_back(ifb.m_data_out_y);
      tick;
      t++;
    end
    y_ready = 1'b0;
    chk("drain_timeout", t < 300, 1);
    chk("ready_x_after_last", ifa.s_ready_x, 1);
    chk("b_no_extra", ifb.m_valid_y, 0);
    chk("lat_p1", fa, 10);
    chk("lat_p2", fb, 7);
    chk("count_p1", qa.size(), 3);
    chk("count_p2", qb.size(), 3);
    while (qa.size() < 3) qa.push_back('x);
    while (qb.size() < 3) qb.push_back('x);
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("y_p1[%0d]", j), qa[j], e[j]);
      chk($sformatf("y_p2[%0d]", j), qb[j], e[j]);
    end
  endtask

  task automatic do_reload;
    reload = 1'b1;
    tick;
    reload = 1'b0;
    chk("reload_ready_f", ifa.s_ready_f, 1);
    chk("reload_ready_x", ifa.s_ready_x, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; f_valid = 1'b0; x_valid = 1'b0; reload = 1'b0; y_ready = 1'b0;
    f_data = '0; x_data = '0;
    tick; tick;
    chk("rst_ready_x", ifa.s_ready_x, 0);
    chk("rst_valid_y", ifa.m_valid_y, 0);
    chk("rst_data_y", ifa.m_data_out_y, 0);
    reset = 1'b0;
    tick;
    chk("rst_ready_f", ifa.s_ready_f, 1);
    chk("rst_ready_x_after", ifb.s_ready_x, 0);

    // Basic vector, ready held high.
    load_f(6, -3, 11);
    send_x(1, 2, 3, 4, 5);
    collect(33, 47, 61, 1'b0);

    // Retained filter, random back-pressure.
    send_x(-1, 0, 2, 1, -3);
    collect(16, 5, r(-24), 1'b1);

    // Reload with identity filter.
    do_reload;
    load_f(1, 0, 0);
    send_x(5, -7, 100, -128, 3);
    collect(5, r(-7), 100, 1'b1);

    // Positive and negative saturation.
    do_reload;
    load_f(127, 127, 127);
    send_x(127, 127, 127, 127, 127);
    collect(127, 127, 127, 1'b0);
    send_x(-128, -128, -128, -128, -128);
    collect(r(-128), r(-128), r(-128), 1'b0);

    // Product saturates before the sum: 127, 127, 127-128 = -1.
    do_reload;
    load_f(100, 100, -100);
    send_x(2, 2, 2, 2, 2);
    collect(r(-1), r(-1), r(-1), 1'b1);

    // Reset mid-COMPUTE, then recover with a fresh filter.
    send_x(1, 2, 3, 4, 5);
    tick; tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("midrst_valid_y", ifa.m_valid_y, 0);
    chk("midrst_ready_f", ifa.s_ready_f, 1);
    chk("midrst_ready_x", ifa.s_ready_x, 0);
    chk("midrst_valid_y_p2", ifb.m_valid_y, 0);
    load_f(6, -3, 11);
    send_x(1, 2, 3, 4, 5);
    collect(33, 47, 61, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
